// File: rtl/nn_pkg.sv
// Shared definitions for the training controller: FSM state encoding and the
// Q6.10 weight format used by the weight registers this block drives.
package nn_pkg;

    localparam int Q_W    = 16;
    localparam int Q_FRAC = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FWD_START,
        ST_FWD_WAIT,
        ST_BWD_START,
        ST_BWD_WAIT,
        ST_UPDATE,
        ST_DONE
    } wu_state_t;

endpackage

// File: rtl/weight_update_ctrl_train_counter.sv
// Sample/epoch counter pair with limits latched at run start; flags the last
// sample of an epoch and the last epoch of a run.
module train_counter #(
    parameter int SAMPLE_W = 4,
    parameter int EPOCH_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                adv,
    input  logic [SAMPLE_W-1:0] num_samples,
    input  logic [EPOCH_W-1:0]  num_epochs,
    output logic [SAMPLE_W-1:0] sample_idx,
    output logic [EPOCH_W-1:0]  epoch_cnt,
    output logic                last_sample,
    output logic                last_epoch,
    output logic                zero_run
);

    logic [SAMPLE_W-1:0] lim_s;
    logic [EPOCH_W-1:0]  lim_e;

    // idx+1 >= limit, widened by one bit so a zero limit never wraps
    assign last_sample = ({1'b0, sample_idx} + (SAMPLE_W+1)'(1)) >= {1'b0, lim_s};
    assign last_epoch  = ({1'b0, epoch_cnt} + (EPOCH_W+1)'(1)) >= {1'b0, lim_e};
    assign zero_run    = (lim_s == '0) || (lim_e == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            lim_s      <= '0;
            lim_e      <= '0;
            sample_idx <= '0;
            epoch_cnt  <= '0;
        end else if (clear) begin
            lim_s      <= num_samples;
            lim_e      <= num_epochs;
            sample_idx <= '0;
            epoch_cnt  <= '0;
        end else if (adv) begin
            if (!last_sample) begin
                sample_idx <= sample_idx + SAMPLE_W'(1);
            end else if (!last_epoch) begin
                sample_idx <= '0;
                epoch_cnt  <= epoch_cnt + EPOCH_W'(1);
            end
        end
    end

endmodule

// File: rtl/weight_update_ctrl.sv
// Training-run sequencer: initialises weights, then loops forward pass,
// backprop and weight update over every sample of every epoch.
module weight_update_ctrl
    import nn_pkg::*;
#(
    parameter int SAMPLE_W = 4,
    parameter int EPOCH_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] num_samples,
    input  logic [EPOCH_W-1:0]  num_epochs,
    input  logic                fwd_done,
    input  logic                bwd_done,
    output logic                fwd_start,
    output logic                bwd_start,
    output logic                select_initial,
    output logic                select_update,
    output logic [SAMPLE_W-1:0] sample_idx,
    output logic [EPOCH_W-1:0]  epoch_cnt,
    output logic                busy,
    output logic                done
);

    wu_state_t state;
    logic      clear, adv;
    logic      last_sample, last_epoch, zero_run;

    assign clear = (state == ST_IDLE) && start;
    assign adv   = (state == ST_UPDATE);

    train_counter #(
        .SAMPLE_W (SAMPLE_W),
        .EPOCH_W  (EPOCH_W)
    ) u_cnt (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .adv         (adv),
        .num_samples (num_samples),
        .num_epochs  (num_epochs),
        .sample_idx  (sample_idx),
        .epoch_cnt   (epoch_cnt),
        .last_sample (last_sample),
        .last_epoch  (last_epoch),
        .zero_run    (zero_run)
    );

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            fwd_start      <= 1'b0;
            bwd_start      <= 1'b0;
            select_initial <= 1'b0;
            select_update  <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            fwd_start      <= 1'b0;
            bwd_start      <= 1'b0;
            select_initial <= 1'b0;
            select_update  <= 1'b0;
            done           <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state          <= ST_INIT;
                    select_initial <= 1'b1;
                    busy           <= 1'b1;
                end
                ST_INIT: if (zero_run) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end else begin
                    state     <= ST_FWD_START;
                    fwd_start <= 1'b1;
                end
                ST_FWD_START: state <= ST_FWD_WAIT;
                ST_FWD_WAIT: if (fwd_done) begin
                    state     <= ST_BWD_START;
                    bwd_start <= 1'b1;
                end
                ST_BWD_START: state <= ST_BWD_WAIT;
                ST_BWD_WAIT: if (bwd_done) begin
                    state         <= ST_UPDATE;
                    select_update <= 1'b1;
                end
                ST_UPDATE: if (last_sample && last_epoch) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end else begin
                    state     <= ST_FWD_START;
                    fwd_start <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
